seq_mode_alu: RTL and testbench

//   Parametrised, clocked multi-mode ALU: unsigned add, iterative shift-add multiply,

---
 rtl/seq_mode_alu.sv | 95 +++++++++
 tb/tb_seq_mode_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_mode_alu.sv
// Clocked multi-mode ALU: add, iterative shift-add multiply, logical right shift, all-ones.
// Single-cycle modes write y at the accept edge; multiply takes WIDTH edges.
module seq_mode_alu #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state;
    logic [W2-1:0]   acc;
    logic [W2-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]  cnt;
    logic [W2-1:0]   acc_step;
    logic [W2-1:0]   res;

    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
    end

    always_comb begin
        res = '0;
        case (mode)
            2'b00:   res = W2'(a) + W2'(b);
            2'b10:   res = W2'(a >> b[SHW-1:0]);
            2'b11:   res = '1;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            zero   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == 2'b01) begin
                            state  <= MUL;
                            busy   <= 1'b1;
                            acc    <= '0;
                            mcand  <= W2'(a);
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            y    <= res;
                            zero <= (res == '0);
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Accumulator stays internal; only the final sum reaches y.
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == CNT_LAST) begin
                        y     <= acc_step;
                        zero  <= (acc_step == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mode_alu.sv
// Directed bench for seq_mode_alu at WIDTH=4 and WIDTH=8, sampling on the falling edge.
module tb_seq_mode_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [1:0]  mode4, mode8;
    logic [7:0]  y4;
    logic [15:0] y8;
    logic        busy4, done4, zero4;
    logic        busy8, done8, zero8;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    seq_mode_alu #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .mode(mode4),
        .y(y4), .busy(busy4), .done(done4), .zero(zero4)
    );

    seq_mode_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .mode(mode8),
        .y(y8), .busy(busy8), .done(done8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse on dut4; returns at the falling edge after the accept edge.
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] mv);
        @(negedge clk);
        a4 = av; b4 = bv; mode4 = mv; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Multiply on dut4; counts falling edges from the start request up to done.
    task automatic mul4(input logic [3:0] av, input logic [3:0] bv, output int cnt);
        @(negedge clk);
        a4 = av; b4 = bv; mode4 = 2'b01; start4 = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cnt++;
        end while (!done4 && cnt < 30);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; mode4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; mode8 = '0;
        repeat (2) @(negedge clk);
        check("rst_y",    y4,    8'h00);
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_zero", zero4, 1'b0);
        rst = 1'b0;

        // add with carry into y[WIDTH]
        op4(4'd15, 4'd15, 2'b00);
        check("add_y",    y4,    8'h1E);
        check("add_done", done4, 1'b1);
        check("add_zero", zero4, 1'b0);
        check("add_busy", busy4, 1'b0);
        @(negedge clk);
        check("add_done_drop", done4, 1'b0);

        // multiply 15*15 with start pulses and operand churn while busy
        a4 = 4'd15; b4 = 4'd15; mode4 = 2'b01; start4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = 4'd1; b4 = 4'd1; mode4 = 2'b00; start4 = 1'b1;
            check("mul_busy", busy4, 1'b1);
            check("mul_nodone", done4, 1'b0);
            check("mul_yhold", y4, 8'h1E);
        end
        @(negedge clk);
        start4 = 1'b0;
        check("mul_y",    y4,    8'hE1);
        check("mul_done", done4, 1'b1);
        check("mul_busy_end", busy4, 1'b0);
        check("mul_zero", zero4, 1'b0);
        @(negedge clk);
        check("mul_single_done", done4, 1'b0);
        check("mul_y_hold", y4, 8'hE1);

        // held start: shift, shift, all-ones back to back
        a4 = 4'b1100; b4 = 4'd2; mode4 = 2'b10; start4 = 1'b1;
        @(negedge clk);
        check("shr2_y", y4, 8'h03);
        check("shr2_done", done4, 1'b1);
        b4 = 4'd3;
        @(negedge clk);
        check("shr3_y", y4, 8'h01);
        check("shr3_done", done4, 1'b1);
        mode4 = 2'b11;
        @(negedge clk);
        start4 = 1'b0;
        check("ones_y", y4, 8'hFF);
        check("ones_done", done4, 1'b1);
        @(negedge clk);
        check("ones_done_drop", done4, 1'b0);

        // zero product sets zero flag, next add clears it
        mul4(4'd0, 4'd9, n);
        check("mul0_lat",  n, 5);
        check("mul0_y",    y4, 8'h00);
        check("mul0_zero", zero4, 1'b1);
        op4(4'd1, 4'd0, 2'b00);
        check("add1_y",    y4, 8'h01);
        check("add1_zero", zero4, 1'b0);

        // reset in second cycle of multiply aborts cleanly
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; mode4 = 2'b01; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("abort_busy_pre", busy4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_y",    y4,    8'h00);
        check("abort_busy", busy4, 1'b0);
        check("abort_done", done4, 1'b0);
        check("abort_zero", zero4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", done4, 1'b0);
        end
        op4(4'd3, 4'd4, 2'b00);
        check("post_rst_y",    y4, 8'h07);
        check("post_rst_done", done4, 1'b1);

        // WIDTH=8: full-range multiply, then add accepted in the done cycle
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd255; mode8 = 2'b01; start8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start8 = 1'b0;
            n++;
        end while (!done8 && n < 30);
        check("w8_mul_lat", n, 9);
        check("w8_mul_y", y8, 16'hFE01);
        check("w8_mul_busy", busy8, 1'b0);
        a8 = 8'd200; b8 = 8'd100; mode8 = 2'b00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_b2b_y",    y8, 16'h012C);
        check("w8_b2b_done", done8, 1'b1);
        check("w8_b2b_busy", busy8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
